// File: rtl/mac_mul_seq_if.sv
// Operand/result handshake bundle for the sequential lane multiplier.
// The master drives requests and consumes results; the slave is the multiplier.
interface mac_mul_seq_if #(
   parameter int MAC_CONF_WIDTH = 3,
   parameter int MAC_MIN_WIDTH  = 8,
   parameter int MAC_INT_WIDTH  = 5*MAC_MIN_WIDTH
) ();
   logic                       en;
   logic                       in_valid;
   logic                       in_ready;
   logic [MAC_CONF_WIDTH-1:0]  cfg;
   logic [4*MAC_MIN_WIDTH-1:0] A;
   logic [MAC_MIN_WIDTH-1:0]   B;
   logic                       out_valid;
   logic                       out_ready;
   logic [MAC_INT_WIDTH-1:0]   C;
   logic                       busy;

   modport master (
      output en, in_valid, cfg, A, B, out_ready,
      input  in_ready, out_valid, C, busy
   );

   modport slave (
      input  en, in_valid, cfg, A, B, out_ready,
      output in_ready, out_valid, C, busy
   );
endinterface

// File: rtl/mac_mul_seq.sv
// Sequential unsigned multiplier: one W x W multiplier is reused over 1, 2 or 4
// lanes of A, accumulating shifted partial products into a registered result.
module mac_mul_seq #(
   parameter int MAC_CONF_WIDTH = 3,
   parameter int MAC_MIN_WIDTH  = 8,
   parameter int MAC_INT_WIDTH  = 5*MAC_MIN_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   mac_mul_seq_if.slave  bus
);
   localparam int W  = MAC_MIN_WIDTH;
   localparam int IW = MAC_INT_WIDTH;

   localparam logic [1:0] MAC_SINGLE = 2'b00;
   localparam logic [1:0] MAC_DUAL   = 2'b01;
   localparam logic [1:0] MAC_QUAD   = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic          rst_meta_r;
   logic          rst_sync_r;
   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic [4*W-1:0] a_r;
   logic [4*W-1:0] a_nxt_s;
   logic [W-1:0]  b_r;
   logic [W-1:0]  b_nxt_s;
   logic [1:0]    mode_r;
   logic [1:0]    mode_nxt_s;
   logic [1:0]    cnt_r;
   logic [1:0]    cnt_nxt_s;
   logic [IW-1:0] acc_r;
   logic [IW-1:0] acc_nxt_s;
   logic [IW-1:0] c_r;
   logic [IW-1:0] c_nxt_s;
   logic          out_valid_r;
   logic          busy_r;
   logic [W-1:0]  lane_s;
   logic [2*W-1:0] prod_s;
   logic [IW-1:0] term_s;

   // Index of the final beat for a given precision mode.
   function automatic logic [1:0] last_beat(input logic [1:0] mode);
      case (mode)
         MAC_SINGLE: last_beat = 2'd0;
         MAC_DUAL:   last_beat = 2'd1;
         MAC_QUAD:   last_beat = 2'd3;
         default:    last_beat = 2'd0;
      endcase
   endfunction

   function automatic logic mode_ok(input logic [1:0] mode);
      mode_ok = (mode == MAC_SINGLE) || (mode == MAC_DUAL) || (mode == MAC_QUAD);
   endfunction

   assign lane_s = a_r[int'(cnt_r)*W +: W];
   assign prod_s = {{W{1'b0}}, lane_s} * {{W{1'b0}}, b_r};
   assign term_s = {{(IW-2*W){1'b0}}, prod_s} << (int'(cnt_r)*W);

   assign bus.in_ready  = (state_r == ST_IDLE) && bus.en && rst_sync_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.C         = c_r;

   // Reset synchroniser: assertion is immediate, release lands on a clean edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta_r <= 1'b0;
         rst_sync_r <= 1'b0;
      end else begin
         rst_meta_r <= 1'b1;
         rst_sync_r <= rst_meta_r;
      end
   end

   // Next-state, operand capture and accumulate; en=0 holds everything.
   always_comb begin
      state_nxt_s = state_r;
      a_nxt_s     = a_r;
      b_nxt_s     = b_r;
      mode_nxt_s  = mode_r;
      cnt_nxt_s   = cnt_r;
      acc_nxt_s   = acc_r;
      c_nxt_s     = c_r;
      if (bus.en) begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  a_nxt_s    = bus.A;
                  b_nxt_s    = bus.B;
                  mode_nxt_s = bus.cfg[1:0];
                  acc_nxt_s  = {IW{1'b0}};
                  cnt_nxt_s  = 2'd0;
                  // Unknown precision codes skip the multiply and report zero.
                  if (mode_ok(bus.cfg[1:0])) begin
                     state_nxt_s = ST_MUL;
                  end else begin
                     state_nxt_s = ST_DONE;
                     c_nxt_s     = {IW{1'b0}};
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_MUL: begin
               acc_nxt_s = acc_r + term_s;
               if (cnt_r == last_beat(mode_r)) begin
                  state_nxt_s = ST_DONE;
                  c_nxt_s     = acc_r + term_s;
               end else begin
                  cnt_nxt_s = cnt_r + 2'd1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and datapath registers; flags are registered from the next state.
   always_ff @(posedge clk or negedge rst_sync_r) begin
      if (!rst_sync_r) begin
         state_r     <= ST_IDLE;
         a_r         <= {(4*W){1'b0}};
         b_r         <= {W{1'b0}};
         mode_r      <= 2'b00;
         cnt_r       <= 2'd0;
         acc_r       <= {IW{1'b0}};
         c_r         <= {IW{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         a_r         <= a_nxt_s;
         b_r         <= b_nxt_s;
         mode_r      <= mode_nxt_s;
         cnt_r       <= cnt_nxt_s;
         acc_r       <= acc_nxt_s;
         c_r         <= c_nxt_s;
         out_valid_r <= (state_nxt_s == ST_DONE);
         busy_r      <= (state_nxt_s != ST_IDLE);
      end
   end
endmodule

// File: tb/tb_mac_mul_seq.sv
// Scoreboard bench for mac_mul_seq: directed cases plus randomized requests,
// checked against a plain-arithmetic product model.
module tb_mac_mul_seq;
   localparam int CW = 3;
   localparam int W  = 8;
   localparam int IW = 40;

   typedef struct {
      logic [IW-1:0] c;
      int            stamp;
      int            lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   en_edges = 0;
   logic ov_prev = 1'b0;
   logic [IW-1:0] held_exp;

   mac_mul_seq_if #(.MAC_CONF_WIDTH(CW), .MAC_MIN_WIDTH(W), .MAC_INT_WIDTH(IW)) m ();

   mac_mul_seq #(.MAC_CONF_WIDTH(CW), .MAC_MIN_WIDTH(W), .MAC_INT_WIDTH(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (m.slave)
   );

   always #5 clk = ~clk;

   // Count enabled edges so latency can be measured in active cycles.
   always @(posedge clk) if (m.en) en_edges <= en_edges + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] model(input logic [CW-1:0] cfg, input logic [31:0] a,
                                           input logic [7:0] b);
      logic [63:0] p;
      case (cfg[1:0])
         2'b00:   p = 64'(a & 32'h0000_00FF) * 64'(b);
         2'b01:   p = 64'(a & 32'h0000_FFFF) * 64'(b);
         2'b10:   p = 64'(a) * 64'(b);
         default: p = 64'd0;
      endcase
      return p[IW-1:0];
   endfunction

   function automatic int beats(input logic [CW-1:0] cfg);
      case (cfg[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   // Monitor: pop on each new result, and check the result stays put while held.
   initial begin
      forever begin
         exp_t e;
         @(negedge clk);
         if (m.out_valid && !ov_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("C", 64'(m.C), 64'(e.c));
               check("latency", 64'(en_edges - e.stamp), 64'(e.lat));
               check("busy_done", 64'(m.busy), 64'd1);
               held_exp = e.c;
            end
         end else if (m.out_valid && ov_prev) begin
            check("C_hold", 64'(m.C), 64'(held_exp));
         end
         ov_prev = m.out_valid;
      end
   end

   task automatic do_req(input logic [CW-1:0] cfg, input logic [31:0] a, input logic [7:0] b,
                         input int stall_at, input int stall_len, input int hold, input bit en_gap);
      exp_t e;
      bit   acc;
      bit   got;
      @(posedge clk); #1;
      m.in_valid = 1'b1; m.cfg = cfg; m.A = a; m.B = b;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         if (m.in_ready) begin
            e.c = model(cfg, a, b);
            e.stamp = en_edges + 1;
            e.lat = beats(cfg);
            exp_q.push_back(e);
            acc = 1'b1;
         end
      end
      if (!acc) begin
         check("accept_timeout", 64'd0, 64'd1);
         m.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      m.in_valid = 1'b0; m.A = $urandom; m.B = 8'($urandom); m.cfg = 3'($urandom);
      if (stall_len > 0) begin
         repeat (stall_at) @(posedge clk);
         #1 m.en = 1'b0;
         repeat (stall_len) @(posedge clk);
         #1 m.en = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         check("busy", 64'(m.busy), 64'd1);
         if (m.out_valid) got = 1'b1;
         else check("in_ready_busy", 64'(m.in_ready), 64'd0);
      end
      if (!got) begin
         check("out_timeout", 64'd0, 64'd1);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("in_ready_done", 64'(m.in_ready), 64'd0);
      end
      if (en_gap) begin
         m.en = 1'b0; m.out_ready = 1'b1;
         repeat (2) @(negedge clk);
         check("en_hold_valid", 64'(m.out_valid), 64'd1);
         m.en = 1'b1;
      end
      m.out_ready = 1'b1;
      @(posedge clk); #1 m.out_ready = 1'b0;
      @(negedge clk);
      check("idle_valid", 64'(m.out_valid), 64'd0);
      check("idle_busy", 64'(m.busy), 64'd0);
      check("idle_C", 64'(m.C), 64'(e.c));
      check("idle_ready", 64'(m.in_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Driver: reset checks, directed cases, then randomized traffic.
   initial begin
      rst = 1'b0;
      m.en = 1'b1; m.in_valid = 1'b1; m.out_ready = 1'b0;
      m.cfg = 3'd0; m.A = 32'd0; m.B = 8'd0;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(m.out_valid), 64'd0);
      check("rst_busy", 64'(m.busy), 64'd0);
      check("rst_C", 64'(m.C), 64'd0);
      check("rst_ready", 64'(m.in_ready), 64'd0);
      @(posedge clk); #1;
      m.in_valid = 1'b0; rst = 1'b1;

      do_req(3'b000, 32'h0000_00F3, 8'h05, 0, 0, 0, 1'b0);
      check("single_C", 64'(m.C), 64'h4BF);
      do_req(3'b010, 32'hFFFF_FFFF, 8'hFF, 0, 0, 0, 1'b0);
      check("quad_max_C", 64'(m.C), 64'hFE_FFFF_FF01);
      do_req(3'b001, 32'hAAAA_1234, 8'h10, 0, 0, 1, 1'b0);
      check("dual_C", 64'(m.C), 64'h12340);
      do_req(3'b010, 32'h1234_5678, 8'h9A, 1, 3, 5, 1'b0);

      // Abort a QUAD operation during its second beat.
      @(posedge clk); #1;
      m.in_valid = 1'b1; m.cfg = 3'b010; m.A = 32'hDEAD_BEEF; m.B = 8'h77;
      @(negedge clk);
      check("abort_ready", 64'(m.in_ready), 64'd1);
      @(posedge clk); #1 m.in_valid = 1'b0;
      @(posedge clk); #2 rst = 1'b0;
      #1;
      check("abort_valid", 64'(m.out_valid), 64'd0);
      check("abort_busy", 64'(m.busy), 64'd0);
      check("abort_C", 64'(m.C), 64'd0);
      check("abort_ready0", 64'(m.in_ready), 64'd0);
      @(posedge clk); #1 rst = 1'b1;
      do_req(3'b000, 32'h0000_0002, 8'h03, 0, 0, 0, 1'b0);
      check("post_abort_C", 64'(m.C), 64'h6);

      do_req(3'b011, 32'h5555_AAAA, 8'hC3, 0, 0, 2, 1'b0);
      check("invalid_C", 64'(m.C), 64'd0);
      do_req(3'b001, 32'h0000_FFFF, 8'hFF, 0, 0, 0, 1'b1);

      for (int t = 0; t < 30; t++) begin
         int sl;
         sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         do_req(3'($urandom_range(0, 7)), $urandom, 8'($urandom),
                int'($urandom_range(0, 2)), sl, int'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0));
      end

      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
